// File: rtl/sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule
//
// SHA-256 message-schedule generator that sits directly in front of the T1
// round term. The block is loaded as 16 word-serial 32-bit writes, M0 first.
// After that it streams W[0..ROUNDS-1], one word per valid/ready handshake,
// together with the round index. A 16-entry shift window holds the message.
// Each W[t+16] is computed on the fly as the oldest word is shifted out.
//
// Parameters
//   ROUNDS   words emitted per block (16..64)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    begin a new block (honoured only while idle)
//   abort    synchronous cancel, wins over start
//   m_valid  message word present
//   m_ready  block is accepting message words
//   m_word   message word, M0 first
//   w_valid  schedule word present
//   w_ready  round stage accepts the schedule word
//   w_word   W[t]
//   w_round  t
//   w_last   marks t == ROUNDS-1
//   busy     block is loading or running
// ---------------------------------------------------------------------------
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_round,
  output logic        w_last,
  output logic        busy
);

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] window_q [16];
  logic [31:0] window_d [16];

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Next-state logic. The window entry leaving at index 0 is W[t]. The
  // entry entering at index 15 is therefore W[t+16], built from
  // W[t+14], W[t+9], W[t+1] and W[t].
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    t_d      = t_q;
    window_d = window_q;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      t_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            count_d = '0;
          end
        end
        LOAD: begin
          if (m_valid) begin
            window_d[count_q] = m_word;
            count_d           = count_q + 4'd1;
            if (count_q == 4'd15) begin
              state_d = RUN;
              t_d     = '0;
            end
          end
        end
        RUN: begin
          if (w_ready) begin
            for (int i = 0; i < 15; i++) begin
              window_d[i] = window_q[i+1];
            end
            window_d[15] = sigma1(window_q[14]) + window_q[9]
                         + sigma0(window_q[1]) + window_q[0];
            t_d = t_q + 6'd1;
            if (t_q == LastRound) begin
              state_d = IDLE;
              t_d     = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      t_q      <= t_d;
      window_q <= window_d;
    end
  end

  // The outputs depend only on state. Data outputs are forced to zero
  // outside RUN so that idle and reset values read as zero.
  always_comb begin
    m_ready = (state_q == LOAD);
    w_valid = (state_q == RUN);
    busy    = (state_q != IDLE);
    w_word  = w_valid ? window_q[0] : '0;
    w_round = w_valid ? t_q : '0;
    w_last  = w_valid && (t_q == LastRound);
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_schedule
//
// Self-checking bench for sha256_msg_schedule. An independent SHA-256
// schedule model fills a queue of expected W values when each block is
// loaded. Each handshake pops one entry and compares it against w_word.
// A table of blocks, each with an anchor word and a known value, drives
// the main loop. Hand-written sequences cover the following:
//   - abort
//   - reset asserted mid-load
//   - abort and start in the same cycle
// ---------------------------------------------------------------------------
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_round;
  logic        w_last;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] expQ [$];
  logic [31:0] got [64];

  localparam logic [511:0] AbcBlk  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] OnesBlk = {16{32'hFFFFFFFF}};
  localparam logic [511:0] MixBlk  = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00000001,
                                      32'h80000000, 32'h7FFFFFFF, 32'hCAFEF00D, 32'h13579BDF,
                                      32'h2468ACE0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h55555555,
                                      32'hAAAAAAAA, 32'h00FF00FF, 32'hFF00FF00, 32'h12345678};

  typedef struct {
    string       name;
    logic [511:0] blk;
    int          gaps;
    int          stallAt;
    int          stallLen;
    int          idx;
    logic [31:0] expW;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_word  (m_word),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_word  (w_word),
    .w_round (w_round),
    .w_last  (w_last),
    .busy    (busy)
  );

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule written in the textbook W[j] form.
  task automatic pushExpected(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int j = 16; j < 64; j++) w[j] = sig1(w[j-2]) + w[j-7] + sig0(w[j-15]) + w[j-16];
    expQ.delete();
    for (int i = 0; i < 64; i++) expQ.push_back(w[i]);
  endtask

  task automatic startBlock();
    checkOutput("busy before start", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("m_ready in load", 32'(m_ready), 32'd1);
  endtask

  // Feeds the 16 words of a block. With gaps set, m_valid toggles every
  // cycle. Once the block is full, junk words stay offered to prove they
  // are not consumed.
  task automatic applyStimulus(input logic [511:0] blk, input int gaps);
    int n   = 0;
    int cyc = 0;
    w_ready = 1'b0;
    while (n < 16 && cyc < 200) begin
      m_valid = (gaps == 0) || (cyc % 2 == 0);
      m_word  = m_valid ? blk[511 - 32*n -: 32] : 32'hBADC0DE5;
      if (m_valid && m_ready) n++;
      tick();
      cyc++;
    end
    checkOutput("load accepts", 32'(n), 32'd16);
    checkOutput("w_valid after 16th accept", 32'(w_valid), 32'd1);
    checkOutput("m_ready after 16th accept", 32'(m_ready), 32'd0);
    if (gaps != 0) begin
      m_valid = 1'b1;
      m_word  = 32'hBADC0DE5;
      for (int k = 0; k < 2; k++) begin
        tick();
        checkOutput("m_ready stays low in run", 32'(m_ready), 32'd0);
        checkOutput("w_round held at 0", 32'(w_round), 32'd0);
      end
    end
    m_valid = 1'b0;
  endtask

  // Streams the block out and compares each handshake with the scoreboard.
  // abortAt >= 0 cancels the block when that round is presented.
  task automatic runBlock(input int stallAt, input int stallLen, input int abortAt);
    int t     = 0;
    int cyc   = 0;
    int stall = 0;
    logic [31:0] exp;
    while (t < 64 && cyc < 300) begin
      checkOutput($sformatf("w_valid t=%0d", t), 32'(w_valid), 32'd1);
      if (!w_valid) break;
      if (t == abortAt) begin
        abort   = 1'b1;
        start   = 1'b1;
        w_ready = 1'b1;
        tick();
        abort   = 1'b0;
        start   = 1'b0;
        checkOutput("w_valid after abort", 32'(w_valid), 32'd0);
        checkOutput("busy after abort", 32'(busy), 32'd0);
        checkOutput("m_ready after abort", 32'(m_ready), 32'd0);
        expQ.delete();
        return;
      end
      w_ready = !(t == stallAt && stall < stallLen);
      if (!w_ready) stall++;
      exp = (expQ.size() > 0) ? expQ[0] : 32'hFFFF_FFFF;
      checkOutput($sformatf("w_word t=%0d", t), w_word, exp);
      checkOutput($sformatf("w_round t=%0d", t), 32'(w_round), 32'(t));
      checkOutput($sformatf("w_last t=%0d", t), 32'(w_last), 32'(t == 63));
      if (w_ready) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        got[t] = w_word;
        t++;
      end
      tick();
      cyc++;
    end
    w_ready = 1'b0;
    checkOutput("handshakes per block", 32'(t), 32'd64);
    checkOutput("w_valid after block", 32'(w_valid), 32'd0);
    checkOutput("busy after block", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{"abc",          AbcBlk,  0, -1, 0,  0, 32'h61626380};
    vecs[1] = '{"abc",          AbcBlk,  0, -1, 0, 16, 32'h61626380};
    vecs[2] = '{"abc",          AbcBlk,  0, -1, 0, 17, 32'h000F0000};
    vecs[3] = '{"ones",         OnesBlk, 0, -1, 0, 16, 32'h203FFFFC};
    vecs[4] = '{"abc stall20",  AbcBlk,  0, 20, 5, 17, 32'h000F0000};
    vecs[5] = '{"abc gaps",     AbcBlk,  1, -1, 0,  0, 32'h61626380};
    vecs[6] = '{"abc gaps",     AbcBlk,  1, -1, 0, 15, 32'h00000018};
    vecs[7] = '{"mix stall5",   MixBlk,  1,  5, 3,  9, 32'h0F0F0F0F};

    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    m_valid = 1'b0;
    m_word  = '0;
    w_ready = 1'b0;
    #2;
    checkOutput("reset m_ready", 32'(m_ready), 32'd0);
    checkOutput("reset w_valid", 32'(w_valid), 32'd0);
    checkOutput("reset w_word", w_word, 32'd0);
    checkOutput("reset w_round", 32'(w_round), 32'd0);
    checkOutput("reset w_last", 32'(w_last), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // A word offered while idle must not open the load window.
    m_valid = 1'b1;
    m_word  = 32'h11111111;
    tick();
    checkOutput("idle m_ready", 32'(m_ready), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);
    m_valid = 1'b0;

    for (int v = 0; v < 8; v++) begin
      startBlock();
      pushExpected(vecs[v].blk);
      applyStimulus(vecs[v].blk, vecs[v].gaps);
      runBlock(vecs[v].stallAt, vecs[v].stallLen, -1);
      checkOutput($sformatf("%s W%0d", vecs[v].name, vecs[v].idx), got[vecs[v].idx], vecs[v].expW);
    end

    // Abort at t=30 (start held with it), then a clean abc block.
    startBlock();
    pushExpected(AbcBlk);
    applyStimulus(AbcBlk, 0);
    runBlock(-1, 0, 30);
    tick();
    checkOutput("idle after abort", 32'(busy), 32'd0);
    startBlock();
    pushExpected(AbcBlk);
    applyStimulus(AbcBlk, 0);
    runBlock(-1, 0, -1);
    checkOutput("abc W0 after abort", got[0], 32'h61626380);

    // Reset asserted mid-load with seven words accepted.
    startBlock();
    for (int i = 0; i < 7; i++) begin
      m_valid = 1'b1;
      m_word  = OnesBlk[511 - 32*i -: 32];
      tick();
    end
    m_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-load reset m_ready", 32'(m_ready), 32'd0);
    checkOutput("mid-load reset busy", 32'(busy), 32'd0);
    checkOutput("mid-load reset w_valid", 32'(w_valid), 32'd0);
    checkOutput("mid-load reset w_word", w_word, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    startBlock();
    pushExpected(AbcBlk);
    applyStimulus(AbcBlk, 0);
    runBlock(-1, 0, -1);
    checkOutput("abc W17 after reset", got[17], 32'h000F0000);

    // Abort and start together while idle: the block stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort+start busy", 32'(busy), 32'd0);
    checkOutput("abort+start m_ready", 32'(m_ready), 32'd0);
    tick();
    checkOutput("abort+start busy later", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
